// File: rtl/song_reader.sv
// Song ROM walker: fetches {note, duration} entries and hands them to the chord
// player one at a time, pacing issues around the player's voice-load latency.
module song_reader #(
  parameter int ADDR_W  = 7,
  parameter int HOLDOFF = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [1:0]        song,
  input  logic              player_ready,
  input  logic [11:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [5:0]        note,
  output logic [5:0]        duration,
  output logic              new_note,
  output logic              song_done
);
  localparam int IW = ADDR_W - 2;
  localparam int CW = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DATA, WAIT_READY, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      song_q, song_d;
  logic [11:0]     stage_q, stage_d;
  logic [5:0]      note_q, note_d, dur_q, dur_d;
  logic            new_note_q, new_note_d;
  logic            done_q, done_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            song_chg;

  assign song_chg = (song != song_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    song_d     = song_q;
    stage_d    = stage_q;
    note_d     = note_q;
    dur_d      = dur_q;
    new_note_d = 1'b0;
    done_d     = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        song_d = song;
        idx_d  = '0;
        last_d = 1'b0;
        if (play) state_d = FETCH;
      end
      FETCH: state_d = song_chg ? IDLE : DATA;
      DATA: begin
        stage_d = rom_data;
        if (song_chg)                 state_d = IDLE;
        else if (rom_data[5:0] == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else                      state_d = WAIT_READY;
      end
      WAIT_READY: begin
        // An issue takes priority over a song change seen in the same cycle.
        if (play && player_ready) begin
          note_d     = stage_q[11:6];
          dur_d      = stage_q[5:0];
          new_note_d = 1'b1;
          cnt_d      = CW'(HOLDOFF);
          state_d    = HOLD;
          // Saturate at the last slot so the address never leaks into the next song.
          if (&idx_q) last_d = 1'b1;
          else        idx_d  = idx_q + 1'b1;
        end else if (song_chg) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == CW'(1)) begin
          if (song_chg)    state_d = IDLE;
          else if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else         state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      song_q     <= '0;
      stage_q    <= '0;
      note_q     <= '0;
      dur_q      <= '0;
      new_note_q <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      song_q     <= song_d;
      stage_q    <= stage_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      new_note_q <= new_note_d;
      done_q     <= done_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rom_addr  = {song_q, idx_q};
  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = new_note_q;
  assign song_done = done_q;
endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: directed scenarios plus randomized songs checked
// against a song-level model of which entries must come out and how.
module tb_song_reader;
  localparam int ADDR_W  = 7;
  localparam int HOLDOFF = 3;
  localparam int GAP     = HOLDOFF + 2;

  logic              clk = 1'b0;
  logic              reset, play, player_ready;
  logic [1:0]        song;
  logic [11:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [5:0]        note, duration;
  logic              new_note, song_done;

  logic [11:0] rom [0:127];
  int          checks = 0, errors = 0, cyc = 0;
  int          pul_t[$];
  logic [5:0]  pul_n[$], pul_d[$];
  logic [6:0]  pul_a[$];
  bit          pul_r[$];
  int          done_t[$];
  logic [5:0]  prev_n, prev_d;
  int          max_addr;
  logic [5:0]  exp_n[$], exp_d[$];
  bit          exp_wrap;

  song_reader #(.ADDR_W(ADDR_W), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .player_ready(player_ready),
    .rom_data(rom_data), .rom_addr(rom_addr), .note(note), .duration(duration),
    .new_note(new_note), .song_done(song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit pr;
    pr = play && player_ready;
    @(posedge clk); #1; cyc++;
    chk("excl", {31'd0, new_note && song_done}, 0);
    if (new_note) begin
      pul_t.push_back(cyc); pul_n.push_back(note); pul_d.push_back(duration);
      pul_a.push_back(rom_addr); pul_r.push_back(pr);
    end else begin
      chk("hold_note", {26'd0, note}, {26'd0, prev_n});
      chk("hold_dur", {26'd0, duration}, {26'd0, prev_d});
    end
    if (song_done) done_t.push_back(cyc);
    prev_n = note; prev_d = duration;
    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
  endtask

  task automatic do_reset();
    reset = 1'b0; play = 1'b0; player_ready = 1'b0; song = 2'd0;
    #1;
    chk("rst_new_note", {31'd0, new_note}, 0);
    chk("rst_song_done", {31'd0, song_done}, 0);
    chk("rst_note", {26'd0, note}, 0);
    chk("rst_dur", {26'd0, duration}, 0);
    chk("rst_addr", {25'd0, rom_addr}, 0);
    prev_n = '0; prev_d = '0;
    tick(); tick();
    reset = 1'b1;
    pul_t.delete(); pul_n.delete(); pul_d.delete(); pul_a.delete(); pul_r.delete();
    done_t.delete();
    max_addr = 0;
  endtask

  task automatic build_exp(input int s);
    exp_n.delete(); exp_d.delete(); exp_wrap = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (rom[s*32+i][5:0] == 6'd0) begin exp_wrap = 1'b0; break; end
      exp_n.push_back(rom[s*32+i][11:6]);
      exp_d.push_back(rom[s*32+i][5:0]);
    end
  endtask

  task automatic run(input int s, input int p_ready, input int p_play, input int budget);
    bit ok;
    ok = 1'b0; song = 2'(s);
    for (int i = 0; i < budget; i++) begin
      player_ready = ($urandom_range(99) < p_ready);
      play         = ($urandom_range(99) < p_play);
      tick();
      if (done_t.size() > 0) begin ok = 1'b1; break; end
    end
    play = 1'b0; player_ready = 1'b0;
    chk("run_timeout", {31'd0, ok}, 1);
  endtask

  task automatic check_song(input int s, input int t0, input bit exact);
    int n;
    build_exp(s);
    n = exp_n.size();
    chk("pulse_count", pul_t.size(), n);
    chk("done_count", done_t.size(), 1);
    chk("addr_bound", {31'd0, max_addr < (s+1)*32}, 1);
    if (pul_t.size() == n) begin
      for (int k = 0; k < n; k++) begin
        chk("pulse_note", {26'd0, pul_n[k]}, {26'd0, exp_n[k]});
        chk("pulse_dur", {26'd0, pul_d[k]}, {26'd0, exp_d[k]});
        chk("pulse_addr", {25'd0, pul_a[k]}, s*32 + ((k+1 > 31) ? 31 : k+1));
        chk("pulse_gated", {31'd0, pul_r[k]}, 1);
        if (k > 0) begin
          chk("pulse_gap_min", {31'd0, (pul_t[k] - pul_t[k-1]) >= GAP}, 1);
          if (exact) chk("pulse_gap", pul_t[k] - pul_t[k-1], GAP);
        end
      end
      if (exact && n > 0) chk("first_latency", pul_t[0] - t0, 4);
      if (done_t.size() == 1) begin
        if (n > 0) begin
          chk("done_after_last", {31'd0, done_t[0] > pul_t[n-1]}, 1);
          if (exact) chk("done_delay", done_t[0] - pul_t[n-1], exp_wrap ? 2 : 4);
        end else if (exact) chk("done_delay0", done_t[0] - t0, 3);
      end
    end
  endtask

  initial begin
    int t0, a0, first_new;
    reset = 1'b0; play = 1'b0; player_ready = 1'b0; song = 2'd0;
    for (int i = 0; i < 128; i++) rom[i] = 12'h041;
    rom[0] = {6'd12, 6'd4}; rom[1] = {6'd16, 6'd2}; rom[2] = {6'd19, 6'd1}; rom[3] = 12'h000;
    rom[64] = {6'd33, 6'd7}; rom[65] = {6'd34, 6'd3}; rom[66] = 12'h000;
    for (int i = 0; i < 32; i++) rom[32+i] = {6'($urandom), 6'($urandom_range(63, 1))};

    // basic song with all ready
    do_reset();
    t0 = cyc; run(0, 100, 100, 200); check_song(0, t0, 1'b1);
    a0 = pul_t.size();
    for (int i = 0; i < 3; i++) tick();
    chk("idle_quiet", pul_t.size(), a0);

    // player stall, then ready stuck high
    do_reset();
    play = 1'b1; player_ready = 1'b1;
    for (int i = 0; i < 20 && pul_t.size() == 0; i++) tick();
    player_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_no_pulse", pul_t.size(), 1);
    chk("stall_note", {26'd0, note}, 12);
    chk("stall_dur", {26'd0, duration}, 4);
    player_ready = 1'b1;
    tick();
    chk("stall_release_pulse", {31'd0, new_note}, 1);
    chk("stall_release_note", {26'd0, note}, 16);
    for (int i = 0; i < 30; i++) tick();
    for (int k = 1; k < pul_t.size(); k++)
      chk("stuck_gap", {31'd0, (pul_t[k] - pul_t[k-1]) >= GAP}, 1);
    play = 1'b0;

    // pause while holding a staged entry
    do_reset();
    play = 1'b1; player_ready = 1'b1;
    for (int i = 0; i < 20 && pul_t.size() == 0; i++) tick();
    player_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    a0 = int'(rom_addr);
    play = 1'b0; player_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("pause_no_pulse", pul_t.size(), 1);
    chk("pause_addr", {25'd0, rom_addr}, a0);
    play = 1'b1;
    tick();
    chk("resume_pulse", {31'd0, new_note}, 1);
    chk("resume_note", {26'd0, note}, 16);
    chk("resume_dur", {26'd0, duration}, 2);
    play = 1'b0;

    // song change mid-song
    do_reset();
    play = 1'b1; player_ready = 1'b1;
    for (int i = 0; i < 20 && pul_t.size() == 0; i++) tick();
    a0 = int'(rom_addr); song = 2'd2; first_new = -1;
    for (int i = 0; i < 40 && pul_t.size() < 2; i++) begin
      tick();
      if (first_new < 0 && int'(rom_addr) != a0) first_new = int'(rom_addr);
    end
    chk("chg_addr", first_new, 32'h40);
    chk("chg_pulses", pul_t.size(), 2);
    if (pul_t.size() == 2) begin
      chk("chg_note", {26'd0, pul_n[1]}, 33);
      chk("chg_dur", {26'd0, pul_d[1]}, 7);
    end
    chk("chg_no_done", done_t.size(), 0);
    play = 1'b0;

    // reset coincident with a pulse
    do_reset();
    play = 1'b1; player_ready = 1'b1;
    for (int i = 0; i < 20 && pul_t.size() == 0; i++) tick();
    chk("pre_rst_pulse", {31'd0, new_note}, 1);
    do_reset();
    t0 = cyc; play = 1'b1; player_ready = 1'b1;
    for (int i = 0; i < 20 && pul_t.size() == 0; i++) tick();
    chk("post_rst_pulses", pul_t.size(), 1);
    if (pul_t.size() == 1) begin
      chk("post_rst_note", {26'd0, pul_n[0]}, 12);
      chk("post_rst_lat", pul_t[0] - t0, 4);
    end
    play = 1'b0;

    // full 32-entry song with no end marker
    do_reset();
    t0 = cyc; run(1, 100, 100, 400); check_song(1, t0, 1'b1);

    // randomized songs, readiness and pauses
    for (int it = 0; it < 8; it++) begin
      int s, pos;
      s = $urandom_range(3);
      for (int i = 0; i < 32; i++) rom[s*32+i] = {6'($urandom), 6'($urandom_range(63, 1))};
      rom[s*32 + $urandom_range(31)][11:6] = 6'd0;
      pos = $urandom_range(40);
      if (pos < 32) rom[s*32+pos][5:0] = 6'd0;
      do_reset();
      t0 = cyc; run(s, 50, 80, 4000); check_song(s, t0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
